// File: rtl/robo_pkg.sv
// Shared types and constants for the grid-robot navigation controller.
package robo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SENSE,
    ST_DECIDE,
    ST_ISSUE,
    ST_SETTLE,
    ST_DONE,
    ST_STUCK
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_ADV,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_REM
  } action_t;

  localparam logic [1:0] ORI_N = 2'd0;
  localparam logic [1:0] ORI_E = 2'd1;
  localparam logic [1:0] ORI_S = 2'd2;
  localparam logic [1:0] ORI_W = 2'd3;

  localparam int MAP_ROWS = 10;
  localparam int MAP_COLS = 20;

  // A left turn is three clockwise quarter turns.
  localparam logic [1:0] LEFT_EXTRA_PULSES = 2'd2;

  function automatic logic [1:0] rot_cw(input logic [1:0] ori);
    return ori + 2'd1;
  endfunction

endpackage

// File: rtl/robo_cmd_issuer.sv
// Turns one action request into its command pulse train, with settle gaps, then acks.
module robo_cmd_issuer
  import robo_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic    clock_i,
  input  logic    reset_i,
  input  logic    go_i,
  input  action_t act_i,
  output logic    avancar_o,
  output logic    girar_o,
  output logic    remover_o,
  output logic    next_pulse_o,
  output logic    ack_o
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_PULSE,
    ISS_SETTLE
  } iss_t;

  iss_t             st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       reps_q, reps_d;
  logic             adv_q, adv_d;
  logic             gir_q, gir_d;
  logic             rem_q, rem_d;
  logic             last_settle;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q   <= ISS_IDLE;
      cnt_q  <= '0;
      reps_q <= '0;
      adv_q  <= 1'b0;
      gir_q  <= 1'b0;
      rem_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      reps_q <= reps_d;
      adv_q  <= adv_d;
      gir_q  <= gir_d;
      rem_q  <= rem_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    reps_d      = reps_q;
    adv_d       = 1'b0;
    gir_d       = 1'b0;
    rem_d       = 1'b0;
    last_settle = (st_q == ISS_SETTLE) && (cnt_q == '0);

    case (st_q)
      ISS_IDLE: begin
        if (go_i) begin
          st_d = ISS_PULSE;
          case (act_i)
            ACT_ADV:   adv_d = 1'b1;
            ACT_REM:   rem_d = 1'b1;
            ACT_RIGHT: gir_d = 1'b1;
            ACT_LEFT: begin
              gir_d  = 1'b1;
              reps_d = LEFT_EXTRA_PULSES;
            end
            default: ;
          endcase
        end
      end
      ISS_PULSE: begin
        st_d  = ISS_SETTLE;
        cnt_d = CNT_W'(SETTLE_CYC - 1);
      end
      ISS_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (reps_q != '0) begin
          reps_d = reps_q - 2'd1;
          gir_d  = 1'b1;
          st_d   = ISS_PULSE;
        end else begin
          st_d = ISS_IDLE;
        end
      end
      default: st_d = ISS_IDLE;
    endcase
  end

  assign avancar_o    = adv_q;
  assign girar_o      = gir_q;
  assign remover_o    = rem_q;
  assign next_pulse_o = last_settle && (reps_q != '0);
  assign ack_o        = last_settle && (reps_q == '0);

endmodule

// File: rtl/robo_controlador.sv
// Left-hand wall-following navigation FSM: senses, decides one action, hands it to the issuer.
//  state  | meaning
//  IDLE   | waiting for start after reset
//  SENSE  | register sensor inputs
//  DECIDE | apply goal / limit / policy priority
//  ISSUE  | command pulse cycle
//  SETTLE | post-pulse wait
//  DONE   | goal reached, flag held
//  STUCK  | step or turn limit hit, flag held
module robo_controlador
  import robo_pkg::*;
#(
  parameter int STEP_W     = 16,
  parameter int MAX_STEPS  = 1000,
  parameter int MAX_TURNS  = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              head_in,
  input  logic              left_in,
  input  logic              under_in,
  input  logic              barrier_in,
  output logic              avancar,
  output logic              girar,
  output logic              remover,
  output logic              busy,
  output logic              done,
  output logic              stuck,
  output logic [STEP_W-1:0] step_count
);

  localparam int TURN_W = $clog2(MAX_TURNS + 1);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              left_turn_q, left_turn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stuck_q, stuck_d;
  logic              head_q, left_q, under_q, barrier_q;
  logic              go;
  action_t           act;
  logic              iss_next_pulse, iss_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      turn_q      <= '0;
      left_turn_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stuck_q     <= 1'b0;
      head_q      <= 1'b0;
      left_q      <= 1'b0;
      under_q     <= 1'b0;
      barrier_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      turn_q      <= turn_d;
      left_turn_q <= left_turn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stuck_q     <= stuck_d;
      if (state_q == ST_SENSE) begin
        head_q    <= head_in;
        left_q    <= left_in;
        under_q   <= under_in;
        barrier_q <= barrier_in;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    turn_d      = turn_q;
    left_turn_d = left_turn_q;
    busy_d      = busy_q;
    done_d      = done_q;
    stuck_d     = stuck_q;
    go          = 1'b0;
    act         = ACT_NONE;

    case (state_q)
      ST_IDLE, ST_DONE, ST_STUCK: begin
        if (start) begin
          state_d     = ST_SENSE;
          step_d      = '0;
          turn_d      = '0;
          left_turn_d = 1'b0;
          done_d      = 1'b0;
          stuck_d     = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_SENSE: state_d = ST_DECIDE;
      ST_DECIDE: begin
        if (under_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if ((step_q == STEP_W'(MAX_STEPS)) || (turn_q == TURN_W'(MAX_TURNS))) begin
          state_d = ST_STUCK;
          stuck_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_ISSUE;
          go      = 1'b1;
          if (!left_q && !left_turn_q) begin
            act         = ACT_LEFT;
            left_turn_d = 1'b1;
          end else if (!head_q) begin
            act         = ACT_ADV;
            left_turn_d = 1'b0;
            turn_d      = '0;
            if (step_q != '1) step_d = step_q + STEP_W'(1);
          end else if (barrier_q) begin
            act = ACT_REM;
          end else begin
            act         = ACT_RIGHT;
            left_turn_d = 1'b0;
            turn_d      = turn_q + TURN_W'(1);
          end
        end
      end
      ST_ISSUE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (iss_ack)             state_d = ST_SENSE;
        else if (iss_next_pulse) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  robo_cmd_issuer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_issuer (
    .clock_i     (clock),
    .reset_i     (reset),
    .go_i        (go),
    .act_i       (act),
    .avancar_o   (avancar),
    .girar_o     (girar),
    .remover_o   (remover),
    .next_pulse_o(iss_next_pulse),
    .ack_o       (iss_ack)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign stuck      = stuck_q;
  assign step_count = step_q;

endmodule
